sd_block_arbiter: RTL and testbench

- Sits upstream of the floppy track buffers and the HDD handshake logic in the Apple II core top.
- Merges their per-channel block requests (channel 0 = floppy 1, channel 1 = HDD, channel 2 = floppy 2) onto the single host block-transfer interface.
- Grants one channel at a time using round-robin order.
- Routes the host ack and buffer traffic back to the granted channel.

---
 rtl/sd_arb_pkg.sv | 28 ++
 rtl/sd_arb_rr_arbiter.sv | 35 +++
 rtl/sd_block_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_sd_block_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the SD block arbiter: FSM state encoding,
// channel numbering and the round-robin pointer step.
package sd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    XFER  = 2'd2
  } state_t;

  localparam int NCH_DEFAULT = 3;

  localparam int CH_FDD1 = 0;
  localparam int CH_HDD  = 1;
  localparam int CH_FDD2 = 2;

  localparam int IDX_W  = 2;
  localparam int XFER_W = 10;
  localparam logic [XFER_W-1:0] XFER_MAX = '1;

  // Pointer moves to the channel after the one just granted, wrapping to 0.
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx,
                                               input int               nch);
    if (int'(idx) >= nch - 1) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/sd_arb_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping modulo NCH. The pointer register lives in the parent.
module rr_arbiter
  import sd_arb_pkg::*;
#(
  parameter int NCH = NCH_DEFAULT
) (
  input  logic [NCH-1:0]   req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NCH-1:0]   gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic found;
  int   ch;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    ch    = 0;
    for (int i = 0; i < NCH; i++) begin
      ch = (int'(ptr_i) + i) % NCH;
      if (!found && req_i[ch]) begin
        found     = 1'b1;
        gnt_o[ch] = 1'b1;
        idx_o     = IDX_W'(ch);
      end
    end
  end

  assign any_o = found;

endmodule

// File: rtl/sd_block_arbiter.sv
// Round-robin merge of floppy/HDD block requests onto the single host block
// interface. Optional ISSUE-phase watchdog is built when SD_ARB_TIMEOUT_EN is defined.
module sd_block_arbiter
  import sd_arb_pkg::*;
#(
  parameter int NCH            = NCH_DEFAULT,
  parameter int LBA_W          = 32,
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH*LBA_W-1:0] sd_lba,
  input  logic [NCH-1:0]       sd_rd,
  input  logic [NCH-1:0]       sd_wr,
  output logic [NCH-1:0]       sd_ack,
  input  logic [NCH*8-1:0]     sd_buff_din,
  output logic [8:0]           sd_buff_addr,
  output logic [7:0]           sd_buff_dout,
  output logic                 sd_buff_wr,
  output logic [LBA_W-1:0]     host_lba,
  output logic                 host_rd,
  output logic                 host_wr,
  input  logic                 host_ack,
  input  logic [8:0]           host_buff_addr,
  input  logic [7:0]           host_buff_dout,
  output logic [7:0]           host_buff_din,
  input  logic                 host_buff_wr,
  output logic                 grant_valid,
  output logic [1:0]           grant_idx,
  output logic [9:0]           xfer_bytes,
  output logic                 timeout_err
);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d;
  logic [LBA_W-1:0]    lba_q, lba_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [NCH-1:0]      ack_q, ack_d;
  logic [XFER_W-1:0]   xfer_q, xfer_d;
  logic                hack_q;

  logic [NCH-1:0]      pend;
  logic [NCH-1:0]      arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;
  logic [LBA_W-1:0]    arb_lba;
  logic [NCH-1:0]      gnt_oh;
  logic [7:0]          din_sel;
  logic                ack_rise;
  logic                ack_fall;
  logic                in_xfer;
  logic                timeout_hit;

  assign pend     = sd_rd | sd_wr;
  assign ack_rise = host_ack & ~hack_q;
  assign ack_fall = ~host_ack & hack_q;
  assign in_xfer  = (state_q == XFER);

  rr_arbiter #(.NCH(NCH)) u_rr (
    .req_i (pend),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      lba_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ack_q   <= '0;
      xfer_q  <= '0;
      hack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      lba_q   <= lba_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ack_q   <= ack_d;
      xfer_q  <= xfer_d;
      hack_q  <= host_ack;
    end
  end

  // A host_ack edge seen in IDLE is ignored because only ISSUE/XFER look at it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arb_any) state_d = ISSUE;
      ISSUE: begin
        if (ack_rise)         state_d = XFER;
        else if (timeout_hit) state_d = IDLE;
      end
      XFER:    if (ack_fall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    arb_lba = '0;
    gnt_oh  = '0;
    din_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (arb_gnt[i]) arb_lba = arb_lba | sd_lba[i*LBA_W +: LBA_W];
      if (gidx_q == IDX_W'(i)) begin
        gnt_oh[i] = 1'b1;
        din_sel   = sd_buff_din[i*8 +: 8];
      end
    end
  end

  // Request bits are latched at grant; a requester dropping its level in
  // ISSUE does not cancel the host request already in flight.
  always_comb begin
    ptr_d  = ptr_q;
    gidx_d = gidx_q;
    lba_d  = lba_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    ack_d  = ack_q;
    xfer_d = xfer_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          gidx_d = arb_idx;
          lba_d  = arb_lba;
          rd_d   = |(sd_rd & arb_gnt);
          wr_d   = |(sd_wr & arb_gnt);
          ptr_d  = rr_next(arb_idx, NCH);
        end
      end
      ISSUE: begin
        if (ack_rise) begin
          rd_d   = 1'b0;
          wr_d   = 1'b0;
          ack_d  = gnt_oh;
          xfer_d = '0;
        end else if (timeout_hit) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
        end
      end
      XFER: begin
        if (host_buff_wr && (xfer_q != XFER_MAX)) xfer_d = xfer_q + 1'b1;
        if (ack_fall) ack_d = '0;
      end
      default: ;
    endcase
  end

`ifdef SD_ARB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            terr_q, terr_d;

  // Reloaded every IDLE cycle so ISSUE always starts with a full budget.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == IDLE)
      to_cnt_d = TO_W'(TIMEOUT_CYCLES - 1);
    else if ((state_q == ISSUE) && (to_cnt_q != '0))
      to_cnt_d = to_cnt_q - 1'b1;
  end

  assign timeout_hit = (state_q == ISSUE) && (to_cnt_q == '0);
  assign terr_d      = timeout_hit && !ack_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
      terr_q   <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      terr_q   <= terr_d;
    end
  end

  assign timeout_err = terr_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign sd_ack        = ack_q;
  assign host_lba      = lba_q;
  assign host_rd       = rd_q;
  assign host_wr       = wr_q;
  assign grant_valid   = (state_q != IDLE);
  assign grant_idx     = gidx_q;
  assign xfer_bytes    = xfer_q;
  assign sd_buff_addr  = host_buff_addr;
  assign sd_buff_dout  = host_buff_dout;
  assign sd_buff_wr    = host_buff_wr & in_xfer;
  assign host_buff_din = in_xfer ? din_sel : 8'h00;

endmodule

// File: tb/tb_sd_block_arbiter.sv
// Self-checking bench for sd_block_arbiter: randomized requests and transfers
// checked against a pending-table / pointer model of round-robin arbitration.
module tb_sd_block_arbiter;

  localparam int NCH   = 3;
  localparam int LBA_W = 32;
  localparam int TO    = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NCH*LBA_W-1:0] sd_lba;
  logic [NCH-1:0]       sd_rd, sd_wr, sd_ack;
  logic [NCH*8-1:0]     sd_buff_din;
  logic [8:0]           sd_buff_addr, host_buff_addr;
  logic [7:0]           sd_buff_dout, host_buff_dout, host_buff_din;
  logic                 sd_buff_wr, host_rd, host_wr, host_ack, host_buff_wr;
  logic [LBA_W-1:0]     host_lba;
  logic                 grant_valid, timeout_err;
  logic [1:0]           grant_idx;
  logic [9:0]           xfer_bytes;

  always #5 clk = ~clk;

  sd_block_arbiter #(.NCH(NCH), .LBA_W(LBA_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_din(sd_buff_din), .sd_buff_addr(sd_buff_addr),
    .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr), .host_lba(host_lba),
    .host_rd(host_rd), .host_wr(host_wr), .host_ack(host_ack),
    .host_buff_addr(host_buff_addr), .host_buff_dout(host_buff_dout),
    .host_buff_din(host_buff_din), .host_buff_wr(host_buff_wr),
    .grant_valid(grant_valid), .grant_idx(grant_idx), .xfer_bytes(xfer_bytes),
    .timeout_err(timeout_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: what each requester is asking for, and where the search starts.
  logic        m_rd  [NCH];
  logic        m_wr  [NCH];
  logic [31:0] m_lba [NCH];
  int          ptr_m;
  logic        cur_rd, cur_wr;
  logic [31:0] cur_lba;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    for (int c = 0; c < NCH; c++) begin
      sd_rd[c] = m_rd[c];
      sd_wr[c] = m_wr[c];
      sd_lba[c*LBA_W +: LBA_W] = m_lba[c];
    end
  endtask

  task automatic set_req(input int c, input logic [31:0] lba, input logic rd, input logic wr);
    m_rd[c] = rd;
    m_wr[c] = wr;
    m_lba[c] = lba;
  endtask

  function automatic int model_pick();
    for (int k = 0; k < NCH; k++) begin
      int c = (ptr_m + k) % NCH;
      if (m_rd[c] || m_wr[c]) return c;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    host_ack = 1'b0; host_buff_wr = 1'b0; host_buff_addr = '0; host_buff_dout = '0;
    sd_buff_din = '0;
    for (int c = 0; c < NCH; c++) set_req(c, 32'h0, 1'b0, 1'b0);
    drive_reqs();
    ptr_m = 0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic check_grant(output int g);
    g = model_pick();
    if (g < 0) begin
      n_cmp++; n_err++;
      $display("FAIL model_pick: got no pending channel want one");
      g = 0;
    end
    tick();
    n_cmp++; if (grant_valid !== 1'b1) begin n_err++; $display("FAIL grant_valid: got %b want 1", grant_valid); end
    n_cmp++; if (grant_idx !== 2'(g)) begin n_err++; $display("FAIL grant_idx: got %0d want %0d", grant_idx, g); end
    n_cmp++; if (host_lba !== m_lba[g]) begin n_err++; $display("FAIL host_lba: got %h want %h", host_lba, m_lba[g]); end
    n_cmp++; if (host_rd !== m_rd[g]) begin n_err++; $display("FAIL host_rd@grant: got %b want %b", host_rd, m_rd[g]); end
    n_cmp++; if (host_wr !== m_wr[g]) begin n_err++; $display("FAIL host_wr@grant: got %b want %b", host_wr, m_wr[g]); end
    n_cmp++; if (sd_ack !== 3'b000) begin n_err++; $display("FAIL sd_ack@grant: got %b want 000", sd_ack); end
    cur_rd = m_rd[g]; cur_wr = m_wr[g]; cur_lba = m_lba[g];
    ptr_m = (g + 1) % NCH;
  endtask

  // Drives one full host transfer on granted channel g; starts in ISSUE, ends in IDLE.
  task automatic run_xfer(input int g, input int w, input int nbytes, output int seen);
    logic [NCH-1:0] oh;
    logic [7:0]     din_exp;
    logic           strobe;
    int             sent;
    int             exp_cnt;
    oh = '0; oh[g] = 1'b1;
    seen = 0; sent = 0; exp_cnt = 0;
    for (int i = 0; i < w; i++) begin
      host_buff_wr = 1'b1; host_buff_dout = 8'($urandom); sd_buff_din = 24'($urandom);
      if ($urandom_range(0, 3) == 0) begin m_rd[g] = 1'b0; m_wr[g] = 1'b0; drive_reqs(); end
      #1;
      n_cmp++; if (sd_buff_wr !== 1'b0) begin n_err++; $display("FAIL sd_buff_wr@issue: got %b want 0", sd_buff_wr); end
      n_cmp++; if (host_buff_din !== 8'h00) begin n_err++; $display("FAIL host_buff_din@issue: got %h want 00", host_buff_din); end
      tick();
      n_cmp++; if (host_rd !== cur_rd) begin n_err++; $display("FAIL host_rd@issue: got %b want %b", host_rd, cur_rd); end
      n_cmp++; if (host_wr !== cur_wr) begin n_err++; $display("FAIL host_wr@issue: got %b want %b", host_wr, cur_wr); end
      n_cmp++; if (host_lba !== cur_lba) begin n_err++; $display("FAIL host_lba@issue: got %h want %h", host_lba, cur_lba); end
      n_cmp++; if (sd_ack !== 3'b000) begin n_err++; $display("FAIL sd_ack@issue: got %b want 000", sd_ack); end
    end
    host_buff_wr = 1'b0; host_ack = 1'b1;
    #1;
    n_cmp++; if (sd_ack !== 3'b000) begin n_err++; $display("FAIL sd_ack@ackrise: got %b want 000", sd_ack); end
    tick();
    n_cmp++; if (host_rd !== 1'b0) begin n_err++; $display("FAIL host_rd@xfer: got %b want 0", host_rd); end
    n_cmp++; if (host_wr !== 1'b0) begin n_err++; $display("FAIL host_wr@xfer: got %b want 0", host_wr); end
    n_cmp++; if (sd_ack !== oh) begin n_err++; $display("FAIL sd_ack@xfer: got %b want %b", sd_ack, oh); end
    n_cmp++; if (xfer_bytes !== 10'd0) begin n_err++; $display("FAIL xfer_bytes@start: got %0d want 0", xfer_bytes); end
    m_rd[g] = 1'b0; m_wr[g] = 1'b0; drive_reqs();
    while (sent < nbytes) begin
      strobe = ($urandom_range(0, 7) != 0);
      host_buff_wr = strobe; host_buff_addr = 9'($urandom); host_buff_dout = 8'($urandom);
      sd_buff_din = 24'($urandom);
      #1;
      din_exp = sd_buff_din[g*8 +: 8];
      n_cmp++; if (sd_buff_wr !== strobe) begin n_err++; $display("FAIL sd_buff_wr: got %b want %b", sd_buff_wr, strobe); end
      n_cmp++; if (host_buff_din !== din_exp) begin n_err++; $display("FAIL host_buff_din: got %h want %h", host_buff_din, din_exp); end
      n_cmp++; if (sd_buff_addr !== host_buff_addr) begin n_err++; $display("FAIL sd_buff_addr: got %h want %h", sd_buff_addr, host_buff_addr); end
      n_cmp++; if (sd_buff_dout !== host_buff_dout) begin n_err++; $display("FAIL sd_buff_dout: got %h want %h", sd_buff_dout, host_buff_dout); end
      if (sd_buff_wr === 1'b1) seen++;
      if (strobe) sent++;
      tick();
      exp_cnt = (sent > 1023) ? 1023 : sent;
      n_cmp++; if (xfer_bytes !== 10'(exp_cnt)) begin n_err++; $display("FAIL xfer_bytes: got %0d want %0d", xfer_bytes, exp_cnt); end
      n_cmp++; if (sd_ack !== oh) begin n_err++; $display("FAIL sd_ack@data: got %b want %b", sd_ack, oh); end
    end
    host_buff_wr = 1'b0; host_ack = 1'b0;
    #1;
    n_cmp++; if (sd_ack !== oh) begin n_err++; $display("FAIL sd_ack@ackfall: got %b want %b", sd_ack, oh); end
    tick();
    n_cmp++; if (sd_ack !== 3'b000) begin n_err++; $display("FAIL sd_ack@end: got %b want 000", sd_ack); end
    n_cmp++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL grant_valid@end: got %b want 0", grant_valid); end
    n_cmp++; if (xfer_bytes !== 10'(exp_cnt)) begin n_err++; $display("FAIL xfer_bytes@end: got %0d want %0d", xfer_bytes, exp_cnt); end
    n_cmp++; if (host_buff_din !== 8'h00) begin n_err++; $display("FAIL host_buff_din@end: got %h want 00", host_buff_din); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL timeout_err@end: got %b want 0", timeout_err); end
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (sd_ack !== 3'b000) begin n_err++; $display("FAIL rst sd_ack: got %b want 000", sd_ack); end
    n_cmp++; if (host_rd !== 1'b0) begin n_err++; $display("FAIL rst host_rd: got %b want 0", host_rd); end
    n_cmp++; if (host_wr !== 1'b0) begin n_err++; $display("FAIL rst host_wr: got %b want 0", host_wr); end
    n_cmp++; if (host_lba !== 32'h0) begin n_err++; $display("FAIL rst host_lba: got %h want 0", host_lba); end
    n_cmp++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL rst grant_valid: got %b want 0", grant_valid); end
    n_cmp++; if (grant_idx !== 2'd0) begin n_err++; $display("FAIL rst grant_idx: got %0d want 0", grant_idx); end
    n_cmp++; if (xfer_bytes !== 10'd0) begin n_err++; $display("FAIL rst xfer_bytes: got %0d want 0", xfer_bytes); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rst timeout_err: got %b want 0", timeout_err); end
    n_cmp++; if (host_buff_din !== 8'h00) begin n_err++; $display("FAIL rst host_buff_din: got %h want 00", host_buff_din); end
  endtask

  task automatic test_spurious_ack();
    host_ack = 1'b1;
    tick(); tick();
    n_cmp++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL spurious grant_valid: got %b want 0", grant_valid); end
    n_cmp++; if (sd_ack !== 3'b000) begin n_err++; $display("FAIL spurious sd_ack: got %b want 000", sd_ack); end
    host_ack = 1'b0;
    tick();
  endtask

  task automatic test_single_hdd();
    int g, seen;
    set_req(1, 32'h0000_0123, 1'b1, 1'b0);
    drive_reqs();
    check_grant(g);
    run_xfer(g, 2, 4, seen);
  endtask

  task automatic test_rr_wrap();
    int g, seen;
    apply_reset();
    set_req(0, 32'hF00D_0000, 1'b1, 1'b0);
    set_req(2, 32'hF00D_0002, 1'b0, 1'b1);
    drive_reqs();
    check_grant(g); run_xfer(g, 1, 3, seen);
    check_grant(g); run_xfer(g, 0, 3, seen);
    set_req(0, 32'hF00D_0010, 1'b1, 1'b1);
    drive_reqs();
    check_grant(g); run_xfer(g, 1, 2, seen);
  endtask

  task automatic test_xfer_512();
    int g, seen;
    set_req(2, $urandom, 1'b0, 1'b1);
    drive_reqs();
    check_grant(g);
    run_xfer(g, 1, 512, seen);
    n_cmp++; if (seen != 512) begin n_err++; $display("FAIL sd_buff_wr count: got %0d want 512", seen); end
  endtask

  task automatic test_saturate();
    int g, seen;
    set_req(0, $urandom, 1'b1, 1'b0);
    drive_reqs();
    check_grant(g);
    run_xfer(g, 0, 1030, seen);
  endtask

  task automatic test_reset_mid_xfer();
    int g, seen;
    set_req(1, 32'h1111_0001, 1'b1, 1'b0);
    drive_reqs();
    check_grant(g);
    host_ack = 1'b1;
    tick();
    m_rd[1] = 1'b0; drive_reqs();
    host_buff_wr = 1'b1;
    tick(); tick();
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (sd_ack !== 3'b000) begin n_err++; $display("FAIL midrst sd_ack: got %b want 000", sd_ack); end
    n_cmp++; if (host_rd !== 1'b0 || host_wr !== 1'b0) begin n_err++; $display("FAIL midrst host_rd/wr: got %b%b want 00", host_rd, host_wr); end
    n_cmp++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL midrst grant_valid: got %b want 0", grant_valid); end
    n_cmp++; if (grant_idx !== 2'd0) begin n_err++; $display("FAIL midrst grant_idx: got %0d want 0", grant_idx); end
    n_cmp++; if (xfer_bytes !== 10'd0) begin n_err++; $display("FAIL midrst xfer_bytes: got %0d want 0", xfer_bytes); end
    n_cmp++; if (host_lba !== 32'h0) begin n_err++; $display("FAIL midrst host_lba: got %h want 0", host_lba); end
    n_cmp++; if (sd_buff_wr !== 1'b0) begin n_err++; $display("FAIL midrst sd_buff_wr: got %b want 0", sd_buff_wr); end
    n_cmp++; if (host_buff_din !== 8'h00) begin n_err++; $display("FAIL midrst host_buff_din: got %h want 00", host_buff_din); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL midrst timeout_err: got %b want 0", timeout_err); end
    host_ack = 1'b0; host_buff_wr = 1'b0;
    set_req(1, 32'h1111_0011, 1'b1, 1'b0);
    set_req(2, 32'h2222_0022, 1'b0, 1'b1);
    drive_reqs();
    ptr_m = 0;
    tick();
    reset = 1'b0;
    check_grant(g); run_xfer(g, 0, 2, seen);
    check_grant(g); run_xfer(g, 0, 2, seen);
  endtask

  task automatic test_random();
    int g, seen, r;
    logic any;
    for (int it = 0; it < 40; it++) begin
      for (int c = 0; c < NCH; c++) begin
        if (!(m_rd[c] || m_wr[c]) && $urandom_range(0, 1) == 1) begin
          r = $urandom_range(0, 2);
          set_req(c, $urandom, (r != 1), (r != 0));
        end
      end
      any = 1'b0;
      for (int c = 0; c < NCH; c++) if (m_rd[c] || m_wr[c]) any = 1'b1;
      if (!any) set_req($urandom_range(0, NCH-1), $urandom, 1'b1, 1'b0);
      drive_reqs();
      check_grant(g);
      run_xfer(g, $urandom_range(0, 3), $urandom_range(0, 12), seen);
    end
  endtask

`ifdef SD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int g1, g2, seen;
    set_req(0, 32'hDEAD_0000, 1'b1, 1'b0);
    set_req(1, 32'hDEAD_0001, 1'b0, 1'b1);
    drive_reqs();
    check_grant(g1);
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      n_cmp++; if (host_rd !== cur_rd || host_wr !== cur_wr) begin n_err++; $display("FAIL to host_req held: got %b%b want %b%b", host_rd, host_wr, cur_rd, cur_wr); end
      n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL to early pulse: got %b want 0", timeout_err); end
    end
    tick();
    n_cmp++; if (host_rd !== 1'b0 || host_wr !== 1'b0) begin n_err++; $display("FAIL to host_req drop: got %b%b want 00", host_rd, host_wr); end
    n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL to pulse: got %b want 1", timeout_err); end
    n_cmp++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL to idle: got %b want 0", grant_valid); end
    check_grant(g2);
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL to pulse width: got %b want 0", timeout_err); end
    run_xfer(g2, 0, 3, seen);
    check_grant(g1);
    run_xfer(g1, 0, 3, seen);
  endtask
`endif

  initial begin
    test_reset();
    test_spurious_ack();
    test_single_hdd();
    test_rr_wrap();
    test_xfer_512();
    test_saturate();
    test_reset_mid_xfer();
    test_random();
`ifdef SD_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
